// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 digest geometry, reader state encoding, IV constants and byte-swap helper.
package sha_pkg;
    localparam int WORD_W = 32;
    localparam int NUM_WORDS = 8;
    typedef logic [WORD_W*NUM_WORDS-1:0] digest_t;
    typedef enum logic {IDLE, SEND} state_t;
    localparam digest_t SHA256_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/hash_digest_reader_if.sv
// hash_digest_reader_if: digest capture + word stream bundle; TARGET_CMP_EN adds target/hit/hit_valid.
interface hash_digest_reader_if #(
    parameter int WORD_W = sha_pkg::WORD_W,
    parameter int NUM_WORDS = sha_pkg::NUM_WORDS
);
    localparam int IW = $clog2(NUM_WORDS);
    logic                        digest_valid;
    logic [WORD_W*NUM_WORDS-1:0] h_in;
    logic                        busy;
    logic [WORD_W-1:0]           out_word;
    logic                        out_valid;
    logic                        out_ready;
    logic [IW-1:0]               out_index;
    logic                        out_last;
    logic                        drop_err;
`ifdef TARGET_CMP_EN
    logic [WORD_W*NUM_WORDS-1:0] target;
    logic                        hit;
    logic                        hit_valid;
    modport master (output digest_valid, h_in, out_ready, target,
                    input busy, out_word, out_valid, out_index, out_last, drop_err, hit, hit_valid);
    modport slave (input digest_valid, h_in, out_ready, target,
                   output busy, out_word, out_valid, out_index, out_last, drop_err, hit, hit_valid);
`else
    modport master (output digest_valid, h_in, out_ready,
                    input busy, out_word, out_valid, out_index, out_last, drop_err);
    modport slave (input digest_valid, h_in, out_ready,
                   output busy, out_word, out_valid, out_index, out_last, drop_err);
`endif
endinterface

// File: rtl/hash_digest_reader_cmp.sv
// digest_cmp: registered unsigned digest < target compare, H0 most significant; built only with TARGET_CMP_EN.
`ifdef TARGET_CMP_EN
module digest_cmp
    import sha_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_cap,
    input  digest_t i_digest,
    input  digest_t i_target,
    output logic    o_hit,
    output logic    o_hit_valid
);
    logic r_hit, r_hit_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit       <= 1'b0;
            r_hit_valid <= 1'b0;
        end else begin
            r_hit       <= i_cap ? (i_digest < i_target) : r_hit;
            r_hit_valid <= i_cap;
        end
    end
    assign o_hit       = r_hit;
    assign o_hit_valid = r_hit_valid;
endmodule
`endif

// File: rtl/hash_digest_reader.sv
// hash_digest_reader: snapshots H0..H7 on digest_valid and streams them one word per valid/ready handshake.
// Optional macro TARGET_CMP_EN adds a registered digest < target compare (hit/hit_valid).
module hash_digest_reader #(
    parameter int WORD_W = sha_pkg::WORD_W,
    parameter int NUM_WORDS = sha_pkg::NUM_WORDS,
    parameter int BYTE_SWAP = 0
) (
    input logic clk,
    input logic rst,
    hash_digest_reader_if.slave bus
);
    import sha_pkg::*;
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS-1);
    state_t                      r_state, w_state_n;
    logic [WORD_W*NUM_WORDS-1:0] r_shadow, w_shadow_n;
    logic [IW-1:0]               r_index, w_index_n;
    logic [WORD_W-1:0]           r_word, w_word_n, w_sel;
    logic                        r_last, r_drop, w_xfer, w_final, w_cap;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end
    // A capture on the final transfer keeps SEND, so a back-to-back digest streams without a bubble.
    always_comb begin
        w_xfer     = (r_state == SEND) && bus.out_ready;
        w_final    = w_xfer && (r_index == LAST);
        w_cap      = bus.digest_valid && ((r_state == IDLE) || w_final);
        w_state_n  = w_cap ? SEND : (w_final ? IDLE : r_state);
        w_shadow_n = w_cap ? bus.h_in : r_shadow;
        w_index_n  = (w_cap || w_final) ? '0 : (w_xfer ? r_index + 1'b1 : r_index);
        w_sel      = WORD_W'(w_shadow_n >> (WORD_W * (NUM_WORDS - 1 - int'(w_index_n))));
        w_word_n   = (w_state_n == IDLE) ? '0 : ((BYTE_SWAP != 0) ? byte_swap32(w_sel) : w_sel);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_index  <= '0;
            r_word   <= '0;
            r_last   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_shadow <= w_shadow_n;
            r_index  <= w_index_n;
            r_word   <= w_word_n;
            r_last   <= (w_state_n == SEND) && (w_index_n == LAST);
            r_drop   <= r_drop | (bus.digest_valid && !w_cap);
        end
    end
    assign bus.busy      = (r_state == SEND);
    assign bus.out_valid = (r_state == SEND);
    assign bus.out_word  = r_word;
    assign bus.out_index = r_index;
    assign bus.out_last  = r_last;
    assign bus.drop_err  = r_drop;
`ifdef TARGET_CMP_EN
    digest_cmp u_cmp (
        .clk         (clk),
        .rst         (rst),
        .i_cap       (w_cap),
        .i_digest    (bus.h_in),
        .i_target    (bus.target),
        .o_hit       (bus.hit),
        .o_hit_valid (bus.hit_valid)
    );
`endif
endmodule

// File: tb/tb_hash_digest_reader.sv
// tb_hash_digest_reader: randomized scoreboard bench; a plain and a byte-swapped reader share one stimulus stream.
module tb_hash_digest_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    hash_digest_reader_if b0 ();
    hash_digest_reader_if b1 ();
    assign b1.digest_valid = b0.digest_valid;
    assign b1.h_in         = b0.h_in;
    assign b1.out_ready    = b0.out_ready;
`ifdef TARGET_CMP_EN
    assign b1.target       = b0.target;
`endif
    hash_digest_reader #(.BYTE_SWAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    hash_digest_reader #(.BYTE_SWAP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    typedef struct {logic [31:0] w; logic [2:0] idx;} ent_t;
    ent_t exp_q[$];
    int   pend = 0;
    logic m_drop = 1'b0, m_hv = 1'b0, m_hit = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    function automatic logic [31:0] swp(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Reference model: a digest is a list of eight words; it is taken only when nothing is left to send.
    always @(posedge clk) begin
        if (rst) begin
            pend = 0;
            exp_q.delete();
            m_drop = 1'b0;
            m_hv = 1'b0;
            m_hit = 1'b0;
        end else begin
            if (pend > 0 && b0.out_ready) pend--;
            m_hv = 1'b0;
            if (b0.digest_valid) begin
                if (pend == 0) begin
                    for (int i = 0; i < 8; i++) exp_q.push_back('{32'(b0.h_in >> (32 * (7 - i))), 3'(i)});
                    pend = 8;
                    m_hv = 1'b1;
`ifdef TARGET_CMP_EN
                    m_hit = (b0.h_in < b0.target);
`endif
                end else m_drop = 1'b1;
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        chk("valid", b0.out_valid, pend > 0);
        chk("valid_swap", b1.out_valid, pend > 0);
        chk("busy", b0.busy, pend > 0);
        chk("busy_swap", b1.busy, pend > 0);
        chk("drop_err", b0.drop_err, m_drop);
        chk("drop_err_swap", b1.drop_err, m_drop);
`ifdef TARGET_CMP_EN
        chk("hit_valid", b0.hit_valid, m_hv);
        if (m_hv) chk("hit", b0.hit, m_hit);
`endif
        if (!b0.out_valid) chk("last_idle", b0.out_last, 0);
        else if (exp_q.size() == 0) chk("spurious_valid", b0.out_valid, 0);
        else begin
            chk("word", b0.out_word, exp_q[0].w);
            chk("word_swap", b1.out_word, swp(exp_q[0].w));
            chk("index", b0.out_index, exp_q[0].idx);
            chk("index_swap", b1.out_index, exp_q[0].idx);
            chk("last", b0.out_last, exp_q[0].idx == 3'd7);
            chk("last_swap", b1.out_last, exp_q[0].idx == 3'd7);
            if (b0.out_ready) void'(exp_q.pop_front());
        end
    end

    task automatic pulse(input logic [255:0] h);
        b0.digest_valid = 1'b1;
        b0.h_in = h;
        @(negedge clk);
        b0.digest_valid = 1'b0;
    endtask
    task automatic drain();
        int k = 0;
        while (b0.busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", b0.busy, 0);
    endtask
    task automatic wait_idx(input logic [2:0] idx);
        int k = 0;
        while (!(b0.out_valid && b0.out_index == idx) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("wait_index_timeout", b0.out_index, idx);
    endtask

    initial begin
        b0.digest_valid = 1'b0;
        b0.h_in = '0;
        b0.out_ready = 1'b1;
`ifdef TARGET_CMP_EN
        b0.target = {32'h0, {224{1'b1}}};
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_word", b0.out_word, 0);
        chk("rst_index", b0.out_index, 0);
        chk("rst_last", b0.out_last, 0);
        pulse(ABC);
        chk("abc_first", b0.out_word, 32'hba7816bf);
        chk("abc_first_swap", b1.out_word, 32'hbf1678ba);
        repeat (7) @(negedge clk);
        chk("abc_last", b0.out_word, 32'hf20015ad);
        chk("abc_last_swap", b1.out_word, 32'had1500f2);
        chk("abc_last_flag", b0.out_last, 1);
        @(negedge clk);
        chk("abc_busy_low", b0.busy, 0);
        for (int k = 0; k < 30; k++) begin
            b0.out_ready = (k % 3 == 0);
            b0.digest_valid = (k == 0);
            b0.h_in = ABC;
            @(negedge clk);
        end
        b0.digest_valid = 1'b0;
        b0.out_ready = 1'b1;
        drain();
        pulse(rnd256());
        wait_idx(3'd3);
        pulse(rnd256());
        chk("drop_set", b0.drop_err, 1);
        drain();
        pulse(rnd256());
        wait_idx(3'd7);
        pulse(rnd256());
        chk("overlap_restart_index", b0.out_index, 0);
        drain();
        pulse(rnd256());
        wait_idx(3'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", b0.out_valid, 0);
        chk("midrst_busy", b0.busy, 0);
        chk("midrst_drop", b0.drop_err, 0);
        chk("midrst_index", b0.out_index, 0);
`ifdef TARGET_CMP_EN
        pulse({32'h0, 32'h0000ffff, 192'(rnd256())});
        chk("target_hit", b0.hit, 1);
        chk("target_hit_valid", b0.hit_valid, 1);
        @(negedge clk);
        chk("target_hit_valid_drop", b0.hit_valid, 0);
        drain();
        pulse(ABC);
        chk("target_miss", b0.hit, 0);
        drain();
`endif
        for (int k = 0; k < 400; k++) begin
            b0.digest_valid = ($urandom_range(0, 5) == 0);
            b0.h_in = rnd256();
            b0.out_ready = ($urandom_range(0, 9) < 7);
`ifdef TARGET_CMP_EN
            b0.target = rnd256();
`endif
            @(negedge clk);
        end
        b0.digest_valid = 1'b0;
        b0.out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("queue_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
